// File: rtl/stack_pointer_unit.sv
// Downward-growing stack pointer with load, push/pop and registered op_ok pulse.
// Define SP_BOUNDS_CHECK_EN to reject push-while-full / pop-while-empty and to keep sticky ovf/unf flags.
module stack_pointer_unit #(
  parameter int unsigned      WIDTH       = 16,
  parameter logic [WIDTH-1:0] STACK_BASE  = 16'h0100,
  parameter logic [WIDTH-1:0] STACK_LIMIT = 16'h00F0,
  parameter int unsigned      STEP        = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             loadSP,
  input  logic [WIDTH-1:0] insp,
  input  logic             push,
  input  logic             pop,
  input  logic             clr_err,
  output logic [WIDTH-1:0] address,
  output logic             empty,
  output logic             full,
  output logic             op_ok,
  output logic             ovf,
  output logic             unf
);

  localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] FULL_THR = STACK_LIMIT + STEP_W;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_LOAD,
    OP_PUSH,
    OP_POP
  } op_e;

  op_e              op;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic             ok_q, ok_d;

  // Load dominates; simultaneous push and pop cancel to idle.
  always_comb begin
    op = OP_IDLE;
    if (loadSP)             op = OP_LOAD;
    else if (push && !pop)  op = OP_PUSH;
    else if (pop && !push)  op = OP_POP;
  end

  assign empty = (addr_q >= STACK_BASE);
  assign full  = (addr_q < FULL_THR);

`ifdef SP_BOUNDS_CHECK_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;
`else
  logic clr_err_unused;
  assign clr_err_unused = clr_err;
`endif

  always_comb begin
    addr_d = addr_q;
    ok_d   = 1'b0;
`ifdef SP_BOUNDS_CHECK_EN
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    if (clr_err) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
`endif
    case (op)
      OP_LOAD: begin
        addr_d = insp;
`ifdef SP_BOUNDS_CHECK_EN
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
`endif
      end
      OP_PUSH: begin
`ifdef SP_BOUNDS_CHECK_EN
        if (full) ovf_d = 1'b1;
        else
`endif
        begin
          addr_d = addr_q - STEP_W;
          ok_d   = 1'b1;
        end
      end
      OP_POP: begin
`ifdef SP_BOUNDS_CHECK_EN
        if (empty) unf_d = 1'b1;
        else
`endif
        begin
          addr_d = addr_q + STEP_W;
          ok_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= STACK_BASE;
      ok_q   <= 1'b0;
`ifdef SP_BOUNDS_CHECK_EN
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
`endif
    end else begin
      addr_q <= addr_d;
      ok_q   <= ok_d;
`ifdef SP_BOUNDS_CHECK_EN
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
`endif
    end
  end

  assign address = addr_q;
  assign op_ok   = ok_q;
`ifdef SP_BOUNDS_CHECK_EN
  assign ovf = ovf_q;
  assign unf = unf_q;
`else
  assign ovf = 1'b0;
  assign unf = 1'b0;
`endif

endmodule

// File: tb/tb_stack_pointer_unit.sv
// Scoreboard bench for stack_pointer_unit; expectations follow SP_BOUNDS_CHECK_EN.
module tb_stack_pointer_unit;

`ifdef SP_BOUNDS_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        loadSP = 1'b0;
  logic [15:0] insp = '0;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic        clr_err = 1'b0;
  logic [15:0] address;
  logic        empty, full, op_ok, ovf, unf;

  stack_pointer_unit #(
    .WIDTH      (16),
    .STACK_BASE (16'h0100),
    .STACK_LIMIT(16'h00F0),
    .STEP       (2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .loadSP (loadSP),
    .insp   (insp),
    .push   (push),
    .pop    (pop),
    .clr_err(clr_err),
    .address(address),
    .empty  (empty),
    .full   (full),
    .op_ok  (op_ok),
    .ovf    (ovf),
    .unf    (unf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] addr;
    logic        ok;
    logic        ovf;
    logic        unf;
    logic        empty;
    logic        full;
  } obs_t;

  obs_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [15:0] m_addr = 16'h0100;
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;
  obs_t        got, e;

  // Drive one cycle of stimulus, record the predicted post-edge state, sample #1 after the edge.
  task automatic drive(input bit rs, input bit ld, input logic [15:0] ins,
                       input bit pu, input bit po, input bit clr);
    obs_t x;
    logic ok;
    rst = rs; loadSP = ld; insp = ins; push = pu; pop = po; clr_err = clr;
    ok = 1'b0;
    if (rs) begin
      m_addr = 16'h0100; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      if (CHK && clr) begin m_ovf = 1'b0; m_unf = 1'b0; end
      if (ld) begin
        m_addr = ins; m_ovf = 1'b0; m_unf = 1'b0;
      end else if (pu && !po) begin
        if (CHK && m_addr < 16'h00F2) m_ovf = 1'b1;
        else begin m_addr = m_addr - 16'd2; ok = 1'b1; end
      end else if (po && !pu) begin
        if (CHK && m_addr >= 16'h0100) m_unf = 1'b1;
        else begin m_addr = m_addr + 16'd2; ok = 1'b1; end
      end
    end
    x.addr = m_addr; x.ok = ok;
    x.ovf = CHK ? m_ovf : 1'b0; x.unf = CHK ? m_unf : 1'b0;
    x.empty = (m_addr >= 16'h0100); x.full = (m_addr < 16'h00F2);
    exp_q.push_back(x);
    @(posedge clk); #1;
    rst = 1'b0; loadSP = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0;
  endtask

  task automatic test_reset();
    drive(1, 0, '0, 0, 0, 0);
    drive(0, 0, '0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      got = '{address, op_ok, ovf, unf, empty, full};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL reset[%0d] got=%h exp=%h", i, got, e);
      end
    end
    checks++;
    if ({address, empty, full, op_ok, ovf, unf} !== {16'h0100, 5'b10000}) begin
      failures++;
      $display("FAIL reset_const got=%h/%b%b%b%b%b exp=0100/10000", address, empty, full, op_ok, ovf, unf);
    end
  endtask

  task automatic test_push_seq();
    logic [15:0] want;
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, '0, 1, 0, 0);
      got = '{address, op_ok, ovf, unf, empty, full};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL push_seq[%0d] got=%h exp=%h", i, got, e);
      end
      want = 16'h00FE - 16'(2 * i);
      checks++;
      if (address !== want || op_ok !== 1'b1) begin
        failures++;
        $display("FAIL push_addr[%0d] got=%h ok=%b exp=%h ok=1", i, address, op_ok, want);
      end
    end
    checks++;
    if (full !== 1'b1) begin
      failures++;
      $display("FAIL push_full got=%b exp=1", full);
    end
  endtask

  task automatic test_overflow();
    drive(0, 0, '0, 1, 0, 0);
    got = '{address, op_ok, ovf, unf, empty, full};
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL overflow_push got=%h exp=%h", got, e);
    end
    checks++;
    if (CHK && (address !== 16'h00F0 || ovf !== 1'b1 || op_ok !== 1'b0)) begin
      failures++;
      $display("FAIL overflow_const got=%h ovf=%b ok=%b exp=00F0 ovf=1 ok=0", address, ovf, op_ok);
    end
    if (!CHK && (address !== 16'h00EE || ovf !== 1'b0 || op_ok !== 1'b1)) begin
      failures++;
      $display("FAIL overflow_const got=%h ovf=%b ok=%b exp=00EE ovf=0 ok=1", address, ovf, op_ok);
    end
    drive(0, 0, '0, 0, 0, 1);
    got = '{address, op_ok, ovf, unf, empty, full};
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL overflow_clr got=%h exp=%h", got, e);
    end
  endtask

  task automatic test_load_priority();
    drive(0, 1, 16'hA42F, 1, 0, 0);
    drive(0, 0, '0, 1, 1, 0);
    for (int i = 0; i < 2; i++) begin
      got = '{address, op_ok, ovf, unf, empty, full};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL load_prio[%0d] got=%h exp=%h", i, got, e);
      end
    end
    checks++;
    if (address !== 16'hA42F || op_ok !== 1'b0 || ovf !== 1'b0 || unf !== 1'b0) begin
      failures++;
      $display("FAIL load_const got=%h ok=%b ovf=%b unf=%b exp=A42F 0 0 0", address, op_ok, ovf, unf);
    end
  endtask

  task automatic test_underflow();
    drive(1, 0, '0, 0, 0, 0);
    drive(0, 0, '0, 0, 1, 0);
    void'(exp_q.pop_front());
    got = '{address, op_ok, ovf, unf, empty, full};
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL underflow got=%h exp=%h", got, e);
    end
    checks++;
    if (address !== (CHK ? 16'h0100 : 16'h0102) || unf !== CHK) begin
      failures++;
      $display("FAIL underflow_const got=%h unf=%b exp=%h unf=%b", address, unf,
               CHK ? 16'h0100 : 16'h0102, CHK);
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 0, '0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, '0, 1, 0, 0);
    for (int i = 0; i < 4; i++) void'(exp_q.pop_front());
    drive(1, 0, '0, 1, 0, 0);
    got = '{address, op_ok, ovf, unf, empty, full};
    e = exp_q.pop_front();
    checks++;
    if (got !== e || address !== 16'h0100 || op_ok !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got=%h exp=%h", got, e);
    end
  endtask

  task automatic test_wrap();
    drive(0, 1, 16'h0000, 0, 0, 0);
    drive(0, 0, '0, 1, 0, 0);
    drive(0, 1, 16'hFFFF, 0, 0, 0);
    drive(0, 0, '0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      if (i == 3) begin
        got = '{address, op_ok, ovf, unf, empty, full};
        checks++;
        if (got !== e) begin
          failures++;
          $display("FAIL wrap_pop got=%h exp=%h", got, e);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    drive(1, 0, '0, 0, 0, 0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 60; i++) begin
      drive(($urandom_range(0, 29) == 0), ($urandom_range(0, 11) == 0), 16'($urandom_range(16'h00E0, 16'h0110)),
            $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 5) == 0));
      got = '{address, op_ok, ovf, unf, empty, full};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL b2b[%0d] got=%h exp=%h", i, got, e);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_push_seq();
    test_overflow();
    test_load_priority();
    test_underflow();
    test_reset_mid();
    test_wrap();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
